// File: rtl/flicker_ctrl_if.sv
// Control/PWM-side signal bundle for the candle-flicker brightness sequencer.
// The sequencer takes the slave side; run control and the PWM take the master side.
interface flicker_ctrl_if;
   logic       run;
   logic [3:0] step;
   logic       pwm_en;
   logic [7:0] value;
   logic       frame;
   logic       busy;

   modport master (output run, step, input pwm_en, value, frame, busy);
   modport slave  (input run, step, output pwm_en, value, frame, busy);
endinterface

// File: rtl/flicker_ctrl.sv
// Candle-flicker brightness sequencer: prescaled PWM enable, pseudo-random targets, frame-aligned ramps.
// Optional build macro FLICKER_GUST_EN adds occasional deep "gust" dips with a doubled ramp rate.
module flicker_ctrl #(
   parameter int unsigned PRESCALE  = 4,
   parameter logic [7:0]  MIN_LEVEL = 8'd64,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic           clk,
   input logic           reset,
   flicker_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

   state_t      state, state_nx;
   logic [7:0]  pre, pre_nx;
   logic [7:0]  slot, slot_nx;
   logic [15:0] lfsr, lfsr_nx;
   logic [7:0]  value, value_nx;
   logic [7:0]  target, target_nx;
   logic [4:0]  hold, hold_nx;
   logic        gust, gust_nx;
   logic        pwm_en, frame, gust_hit, arrive;
   logic [4:0]  base_step, eff_step;
   logic signed [8:0] diff;
   logic [8:0]  mag;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Returns {gust flag, target}; a gust dip deliberately bypasses the floor.
   function automatic logic [8:0] pick_target(input logic [7:0] r, input logic hit);
      if (hit) return {1'b1, MIN_LEVEL >> 1};
      return {1'b0, (r < MIN_LEVEL) ? MIN_LEVEL : r};
   endfunction

`ifdef FLICKER_GUST_EN
   assign gust_hit = (lfsr[15:12] == 4'hF);
`else
   assign gust_hit = 1'b0;
`endif

   assign pwm_en     = (state != IDLE) && (pre == 8'(PRESCALE - 1));
   assign frame      = pwm_en && (slot == 8'd255);
   assign bus.pwm_en = pwm_en;
   assign bus.frame  = frame;
   assign bus.value  = value;
   assign bus.busy   = (state != IDLE);

   assign base_step = (bus.step == 4'd0) ? 5'd1 : {1'b0, bus.step};
   assign eff_step  = gust ? 5'(base_step << 1) : base_step;
   assign diff      = $signed({1'b0, target}) - $signed({1'b0, value});
   assign mag       = diff[8] ? $unsigned(-diff) : $unsigned(diff);
   assign arrive    = (mag <= {4'b0, eff_step});

   always_comb begin
      state_nx  = state;
      pre_nx    = pre;
      slot_nx   = slot;
      lfsr_nx   = lfsr;
      value_nx  = value;
      target_nx = target;
      hold_nx   = hold;
      gust_nx   = gust;
      if (frame) lfsr_nx = lfsr_adv(lfsr);
      if (!bus.run) begin
         state_nx = IDLE;
         pre_nx   = 8'd0;
         slot_nx  = 8'd0;
         value_nx = 8'd0;
         hold_nx  = 5'd0;
         gust_nx  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               {gust_nx, target_nx} = pick_target(lfsr[7:0], gust_hit);
               lfsr_nx  = lfsr_adv(lfsr);
               state_nx = RAMP;
               pre_nx   = 8'd0;
               slot_nx  = 8'd0;
            end
            default: begin
               pre_nx = pwm_en ? 8'd0 : pre + 8'd1;
               if (pwm_en) slot_nx = slot + 8'd1;
               // Value and phase only move on the period wrap so the PWM never sees a mid-period change.
               if (frame) begin
                  if (state == RAMP) begin
                     if (arrive) begin
                        value_nx = target;
                        hold_nx  = {1'b0, lfsr[11:8]} + 5'd1;
                        gust_nx  = 1'b0;
                        state_nx = HOLD;
                     end else begin
                        value_nx = diff[8] ? value - {3'b0, eff_step} : value + {3'b0, eff_step};
                     end
                  end else begin
                     hold_nx = hold - 5'd1;
                     if (hold == 5'd1) begin
                        {gust_nx, target_nx} = pick_target(lfsr[7:0], gust_hit);
                        state_nx = RAMP;
                     end
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pre   <= 8'd0;
         slot  <= 8'd0;
         lfsr  <= LFSR_SEED;
         value <= 8'd0;
         hold  <= 5'd0;
         gust  <= 1'b0;
      end else begin
         state <= state_nx;
         pre   <= pre_nx;
         slot  <= slot_nx;
         lfsr  <= lfsr_nx;
         value <= value_nx;
         hold  <= hold_nx;
         gust  <= gust_nx;
      end
   end

   always_ff @(posedge clk) begin
      target <= target_nx;
   end
endmodule

// File: tb/tb_flicker_ctrl.sv
// Bench for flicker_ctrl: two instances (default and fast/high-floor) against a cycle-count reference model.
module tb_flicker_ctrl;
   localparam int          PA = 4;
   localparam logic [7:0]  MA = 8'd64;
   localparam logic [15:0] SA = 16'hACE1;
   localparam int          PB = 2;
   localparam logic [7:0]  MB = 8'd200;
   localparam logic [15:0] SB = 16'h1D2B;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [3:0] step;

   always #5 clk = ~clk;

   flicker_ctrl_if bus_a ();
   flicker_ctrl_if bus_b ();
   assign bus_a.run  = run;
   assign bus_a.step = step;
   assign bus_b.run  = run;
   assign bus_b.step = step;

   flicker_ctrl #(.PRESCALE(PA), .MIN_LEVEL(MA), .LFSR_SEED(SA)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   flicker_ctrl #(.PRESCALE(PB), .MIN_LEVEL(MB), .LFSR_SEED(SB)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 50) $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", i, name, act, exp, $time);
      end
   endtask

   // Reference model: time is "cycles since run was seen high", everything else follows from that.
   bit          m_act[2];
   int          m_n[2];
   int          m_val[2];
   int          m_tgt[2];
   int          m_hold[2];
   bit          m_holding[2];
   bit          m_gust[2];
   logic [15:0] m_lfsr[2];
   int          hold_seen[2];

   function automatic int prescale_of(input int i);
      return (i == 0) ? PA : PB;
   endfunction
   function automatic int min_of(input int i);
      return (i == 0) ? int'(MA) : int'(MB);
   endfunction
   function automatic logic [15:0] seed_of(input int i);
      return (i == 0) ? SA : SB;
   endfunction
   function automatic logic [15:0] adv(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic pick(input int i, input logic [15:0] r);
      m_gust[i] = 1'b0;
      m_tgt[i]  = (int'(r[7:0]) < min_of(i)) ? min_of(i) : int'(r[7:0]);
`ifdef FLICKER_GUST_EN
      if (r[15:12] == 4'hF) begin
         m_gust[i] = 1'b1;
         m_tgt[i]  = min_of(i) / 2;
      end
`endif
   endtask

   task automatic model_edge(input int i, input bit rs, input bit rn, input logic [3:0] st);
      bit          f;
      int          es, d;
      logic [15:0] cur;
      f   = m_act[i] && (m_n[i] % (256 * prescale_of(i)) == 0);
      cur = m_lfsr[i];
      if (rs) begin
         m_act[i] = 0; m_n[i] = 0; m_val[i] = 0; m_lfsr[i] = seed_of(i);
         m_holding[i] = 0; m_gust[i] = 0; m_hold[i] = 0;
         return;
      end
      if (f) m_lfsr[i] = adv(cur);
      if (!rn) begin
         m_act[i] = 0; m_n[i] = 0; m_val[i] = 0; m_holding[i] = 0; m_gust[i] = 0; m_hold[i] = 0;
      end else if (!m_act[i]) begin
         m_act[i] = 1; m_n[i] = 1; m_holding[i] = 0;
         pick(i, cur);
         m_lfsr[i] = adv(cur);
      end else begin
         m_n[i]++;
         if (f && !m_holding[i]) begin
            es = (st == 4'd0) ? 1 : int'(st);
            if (m_gust[i]) es = es * 2;
            d = m_tgt[i] - m_val[i];
            if (d <= es && -d <= es) begin
               m_val[i] = m_tgt[i];
               m_hold[i] = int'(cur[11:8]) + 1;
               m_holding[i] = 1; m_gust[i] = 0;
               hold_seen[i]++;
            end else begin
               m_val[i] = m_val[i] + ((d > 0) ? es : -es);
            end
         end else if (f) begin
            m_hold[i]--;
            if (m_hold[i] == 0) begin
               pick(i, cur);
               m_holding[i] = 0;
            end
         end
      end
   endtask

   int         k = 0;
   bit         started = 0;
   bit         seen_pwm[2];
   bit         seen_frm[2];
   logic [7:0] prev_val[2];
   logic       prev_frm[2];

   always @(posedge clk) begin
      bit         rs, rn;
      logic [3:0] st;
      logic [7:0] o_val;
      logic       o_pwm, o_frm, o_busy;
      int         p;
      rs = reset; rn = run; st = step;
      model_edge(0, rs, rn, st);
      model_edge(1, rs, rn, st);
      if (rs || !rn) k = 0; else k++;
      #1;
      if (rs) started = 1;
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            o_val  = (i == 0) ? bus_a.value  : bus_b.value;
            o_pwm  = (i == 0) ? bus_a.pwm_en : bus_b.pwm_en;
            o_frm  = (i == 0) ? bus_a.frame  : bus_b.frame;
            o_busy = (i == 0) ? bus_a.busy   : bus_b.busy;
            p = prescale_of(i);
            chk(i, "busy", 32'(o_busy), 32'(m_act[i]));
            chk(i, "pwm_en", 32'(o_pwm), 32'(m_act[i] && (m_n[i] % p == 0)));
            chk(i, "frame", 32'(o_frm), 32'(m_act[i] && (m_n[i] % (256 * p) == 0)));
            chk(i, "value", 32'(o_val), 32'(m_val[i]));
            if (k == 0) begin
               seen_pwm[i] = 0;
               seen_frm[i] = 0;
            end else begin
               if (!seen_pwm[i] && o_pwm) begin
                  chk(i, "first_pwm_en_delay", 32'(k), 32'(p));
                  seen_pwm[i] = 1;
               end
               if (!seen_frm[i] && o_frm) begin
                  chk(i, "first_frame_delay", 32'(k), 32'(256 * p));
                  seen_frm[i] = 1;
               end
            end
            if (!rs && rn && o_val !== prev_val[i]) chk(i, "value_changes_only_after_frame", 32'(prev_frm[i]), 32'd1);
`ifndef FLICKER_GUST_EN
            if (i == 1 && m_holding[i]) chk(i, "hold_value_floor", 32'(int'(o_val) >= int'(MB)), 32'd1);
`endif
            prev_val[i] = o_val;
            prev_frm[i] = o_frm;
         end
      end
   end

   task automatic random_phase(input int cycles);
      int off = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (off > 0) begin
            off--;
            if (off == 0) run = 1'b1;
         end else if ($urandom_range(0, 17999) == 0) begin
            run = 1'b0;
            off = $urandom_range(1, 40);
         end
         if ($urandom_range(0, 399) == 0) step = 4'($urandom_range(0, 15));
      end
      run = 1'b1;
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; step = 4'd15;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (2000) @(negedge clk);
      chk(0, "idle_busy", 32'(bus_a.busy), 32'd0);
      chk(0, "idle_value", 32'(bus_a.value), 32'd0);

      // Seed ACE1 gives first target 225 and B's seed gives 43 -> floored to 200; step 15 from zero.
      run = 1'b1;
      repeat (1100) @(negedge clk);
      chk(0, "first_ramp_value", 32'(bus_a.value), 32'd15);
      chk(1, "second_ramp_value", 32'(bus_b.value), 32'd30);

      run = 1'b0;
      @(negedge clk);
      chk(0, "drop_busy", 32'(bus_a.busy), 32'd0);
      chk(0, "drop_value", 32'(bus_a.value), 32'd0);
      chk(1, "drop_pwm_en", 32'(bus_b.pwm_en), 32'd0);
      repeat (3) @(negedge clk);
      run = 1'b1;

      random_phase(55000);

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk(0, "reset_over_run_busy", 32'(bus_a.busy), 32'd0);
      chk(1, "reset_over_run_value", 32'(bus_b.value), 32'd0);
      reset = 1'b0;

      random_phase(20000);
      repeat (2) @(negedge clk);
      chk(1, "hold_reached", 32'(hold_seen[1] > 0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
